// File: rtl/serial_adder_8bit.sv
// Bit-serial WIDTH-bit adder: one full_adder_1bit cell, LSB first, start/busy/done handshake.
// Optional build macro SERIAL_ADDER_CIN_EN adds a carry-in port captured with the operands.

module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);
    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder_8bit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             cin,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] acc_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             c_out_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic             init_carry_s;
    logic [WIDTH-1:0] acc_next_s;

    full_adder_1bit u_fa (
        .a     (a_sh_r[0]),
        .b     (b_sh_r[0]),
        .c_in  (carry_r),
        .s     (fa_sum_s),
        .c_out (fa_cout_s)
    );

    // Initial carry selection and LSB-first assembly of the next partial result.
    always_comb begin
`ifdef SERIAL_ADDER_CIN_EN
        init_carry_s = cin;
`else
        init_carry_s = 1'b0;
`endif
        acc_next_s = {fa_sum_s, acc_r[WIDTH-1:1]};
    end

    // Control FSM, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            c_out_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= init_carry_s;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= S_ADD;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                S_ADD: begin
                    a_sh_r  <= a_sh_r >> 1;
                    b_sh_r  <= b_sh_r >> 1;
                    acc_r   <= acc_next_s;
                    carry_r <= fa_cout_s;
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    // Final bit: publish the whole result in one edge so sum never shows a partial value.
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        sum_r   <= acc_next_s;
                        c_out_r <= fa_cout_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_ADD;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign sum   = sum_r;
    assign c_out = c_out_r;

endmodule
